// File: rtl/imem_loader_if.sv
// Host byte link, imem write port and status lines of the program loader.
// master = host side driving the byte stream, slave = the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wd;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wd, cpu_hold, busy, done, err
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wd, cpu_hold, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: turns a length-prefixed little-endian byte stream into sequential
// imem word writes and holds the core until the whole image has been written.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave lif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    BYTES = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t            state_r;
  logic [15:0]       len_r;
  logic [ADDR_W-1:0] idx_r;
  logic [1:0]        cnt_r;
  logic [31:0]       wd_r;
  logic [15:0]       len_in_s;
  logic              last_s;
  logic              xfer_s;

  assign len_in_s = {lif.rx_data, len_r[7:0]};
  assign last_s   = ({{(16-ADDR_W){1'b0}}, idx_r} == (len_r - 16'd1));
  assign xfer_s   = lif.rx_valid & lif.rx_ready;

  // Loader FSM; every output is a register updated together with the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      len_r         <= 16'd0;
      idx_r         <= '0;
      cnt_r         <= 2'd0;
      wd_r          <= 32'd0;
      lif.rx_ready  <= 1'b0;
      lif.imem_we   <= 1'b0;
      lif.imem_addr <= '0;
      lif.imem_wd   <= 32'd0;
      lif.cpu_hold  <= 1'b1;
      lif.busy      <= 1'b0;
      lif.done      <= 1'b0;
      lif.err       <= 1'b0;
    end else begin
      lif.imem_we <= 1'b0;
      case (state_r)
        IDLE, DONE, ERR: begin
          if (lif.start) begin
            state_r      <= LEN0;
            idx_r        <= '0;
            cnt_r        <= 2'd0;
            lif.rx_ready <= 1'b1;
            lif.busy     <= 1'b1;
            lif.cpu_hold <= 1'b1;
            lif.done     <= 1'b0;
            lif.err      <= 1'b0;
          end
        end
        LEN0: begin
          if (xfer_s) begin
            len_r[7:0] <= lif.rx_data;
            state_r    <= LEN1;
          end
        end
        LEN1: begin
          if (xfer_s) begin
            len_r <= len_in_s;
            if (len_in_s == 16'd0) begin
              state_r      <= DONE;
              lif.rx_ready <= 1'b0;
              lif.busy     <= 1'b0;
              lif.done     <= 1'b1;
              lif.cpu_hold <= 1'b0;
            end else if ({1'b0, len_in_s} > CAP) begin
              state_r      <= ERR;
              lif.rx_ready <= 1'b0;
              lif.busy     <= 1'b0;
              lif.err      <= 1'b1;
            end else begin
              state_r <= BYTES;
              cnt_r   <= 2'd0;
            end
          end
        end
        // Bytes shift in from the top so the first byte ends up in wd[7:0] after four transfers.
        BYTES: begin
          if (xfer_s) begin
            wd_r  <= {lif.rx_data, wd_r[31:8]};
            cnt_r <= cnt_r + 2'd1;
            if (cnt_r == 2'd3) begin
              state_r       <= WRITE;
              lif.rx_ready  <= 1'b0;
              lif.imem_we   <= 1'b1;
              lif.imem_addr <= idx_r;
              lif.imem_wd   <= {lif.rx_data, wd_r[31:8]};
            end
          end
        end
        // The index is not advanced past the final word, so a full-capacity image never wraps.
        WRITE: begin
          if (last_s) begin
            state_r      <= DONE;
            lif.busy     <= 1'b0;
            lif.done     <= 1'b1;
            lif.cpu_hold <= 1'b0;
          end else begin
            state_r      <= BYTES;
            idx_r        <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            lif.rx_ready <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          lif.rx_ready <= 1'b0;
          lif.busy     <= 1'b0;
          lif.cpu_hold <= 1'b1;
          lif.done     <= 1'b0;
          lif.err      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed vector table, hand-written corner sequences
// and randomized streams checked against a stream-level reference model.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       rx_valid;
  logic [7:0] rx_data;
  int         sel;
  int         nchk = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(8)) if8 ();
  imem_loader_if #(.ADDR_W(2)) if2 ();

  assign if8.start    = start & (sel == 0);
  assign if8.rx_valid = rx_valid & (sel == 0);
  assign if8.rx_data  = rx_data;
  assign if2.start    = start & (sel == 1);
  assign if2.rx_valid = rx_valid & (sel == 1);
  assign if2.rx_data  = rx_data;

  imem_loader #(.ADDR_W(8)) u8 (.clk(clk), .reset(reset), .lif(if8.slave));
  imem_loader #(.ADDR_W(2)) u2 (.clk(clk), .reset(reset), .lif(if2.slave));

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t q8[$];
  wr_t q2[$];

  // Record every write pulse seen on either imem port.
  always @(negedge clk) begin
    if (if8.imem_we) q8.push_back({if8.imem_addr, if8.imem_wd});
    if (if2.imem_we) q2.push_back({6'd0, if2.imem_addr, if2.imem_wd});
  end

  typedef struct packed {
    logic        s;
    logic [7:0]  nb;
    logic [95:0] bytes;
    logic [7:0]  nw;
    logic [63:0] w;
    logic        done;
    logic        err;
  } vec_t;

  logic [7:0] sq[$];
  wr_t        eq[$];
  logic       e_done;
  logic       e_err;
  int         e_bytes;

  function automatic logic cur_rdy();
    return (sel == 1) ? if2.rx_ready : if8.rx_ready;
  endfunction
  function automatic logic cur_busy();
    return (sel == 1) ? if2.busy : if8.busy;
  endfunction
  function automatic logic cur_done();
    return (sel == 1) ? if2.done : if8.done;
  endfunction
  function automatic logic cur_err();
    return (sel == 1) ? if2.err : if8.err;
  endfunction
  function automatic logic cur_hold();
    return (sel == 1) ? if2.cpu_hold : if8.cpu_hold;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream-level model: length header, capacity rule, little-endian word assembly.
  task automatic model(input int cap);
    int n;
    n = int'({sq[1], sq[0]});
    eq.delete();
    e_bytes = 2;
    e_done  = 1'b0;
    e_err   = 1'b0;
    if (n == 0) e_done = 1'b1;
    else if (n > cap) e_err = 1'b1;
    else begin
      e_done  = 1'b1;
      e_bytes = 2 + 4 * n;
      for (int i = 0; i < n; i++)
        eq.push_back({8'(i), sq[2+4*i+3], sq[2+4*i+2], sq[2+4*i+1], sq[2+4*i]});
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rdy8"}, if8.rx_ready, 1'b0);
    chk({tag, "_we8"}, if8.imem_we, 1'b0);
    chk({tag, "_addr8"}, if8.imem_addr, 8'd0);
    chk({tag, "_wd8"}, if8.imem_wd, 32'd0);
    chk({tag, "_hold8"}, if8.cpu_hold, 1'b1);
    chk({tag, "_busy8"}, if8.busy, 1'b0);
    chk({tag, "_done8"}, if8.done, 1'b0);
    chk({tag, "_err8"}, if8.err, 1'b0);
    chk({tag, "_hold2"}, if2.cpu_hold, 1'b1);
    chk({tag, "_busy2"}, if2.busy, 1'b0);
    chk({tag, "_rdy2"}, if2.rx_ready, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    logic x;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        start    = ($urandom_range(3, 0) == 0);
        step();
        start = 1'b0;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    do begin
      x = cur_rdy();
      step();
      t++;
    end while (!x && t < 100);
    if (!x) chk("rx_timeout", 32'd0, 32'd1);
    rx_valid = 1'b0;
  endtask

  task automatic run_stream(input int s, input bit gaps);
    int  t;
    wr_t wq[$];
    sel = s;
    q8.delete();
    q2.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rdy_after_start", cur_rdy(), 1'b1);
    chk("busy_after_start", cur_busy(), 1'b1);
    chk("hold_after_start", cur_hold(), 1'b1);
    for (int i = 0; i < e_bytes; i++) send_byte(sq[i], gaps);
    t = 0;
    while (cur_busy() && t < 20) begin
      step();
      t++;
    end
    chk("busy_end", cur_busy(), 1'b0);
    chk("done_end", cur_done(), e_done);
    chk("err_end", cur_err(), e_err);
    chk("hold_end", cur_hold(), !e_done);
    chk("rdy_end", cur_rdy(), 1'b0);
    if (s == 1) wq = q2;
    else wq = q8;
    chk("n_writes", wq.size(), eq.size());
    for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
      chk("wr_addr", wq[i].a, eq[i].a);
      chk("wr_data", wq[i].d, eq[i].d);
    end
  endtask

  task automatic load_vec(input vec_t v);
    sq.delete();
    eq.delete();
    for (int i = 0; i < v.nb; i++) sq.push_back(v.bytes[8*i +: 8]);
    for (int i = 0; i < v.nw; i++) eq.push_back({8'(i), v.w[32*i +: 32]});
    e_done  = v.done;
    e_err   = v.err;
    e_bytes = v.nb;
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{s: 1'b0, nb: 8'd10, bytes: 96'h0000_0000_006F_0010_0513_0002, nw: 8'd2,
               w: {32'h0000_006F, 32'h0010_0513}, done: 1'b1, err: 1'b0};
    tbl[1] = '{s: 1'b0, nb: 8'd2, bytes: 96'h0000, nw: 8'd0, w: 64'd0, done: 1'b1, err: 1'b0};
    tbl[2] = '{s: 1'b0, nb: 8'd2, bytes: 96'h0101, nw: 8'd0, w: 64'd0, done: 1'b0, err: 1'b1};
    tbl[3] = '{s: 1'b1, nb: 8'd2, bytes: 96'h0005, nw: 8'd0, w: 64'd0, done: 1'b0, err: 1'b1};
    tbl[4] = '{s: 1'b1, nb: 8'd6, bytes: 96'h0000_0000_0000_DEAD_BEEF_0001, nw: 8'd1,
               w: {32'd0, 32'hDEAD_BEEF}, done: 1'b1, err: 1'b0};

    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    sel      = 0;
    step();
    step();
    check_reset("rst");
    reset = 1'b0;
    step();

    foreach (tbl[i]) begin
      load_vec(tbl[i]);
      run_stream(int'(tbl[i].s), 1'b0);
    end

    // err clears on the following start
    sel   = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err_cleared", if8.err, 1'b0);

    // reset in the middle of a load, then a fresh load
    step();
    load_vec(tbl[0]);
    for (int i = 0; i < 6; i++) send_byte(sq[i], 1'b0);
    #2 reset = 1'b1;
    #1 check_reset("midrst");
    step();
    reset = 1'b0;
    step();
    run_stream(0, 1'b0);

    // N=3 with random gaps and ignored start pulses
    sq = '{8'h03, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00,
           8'h6F, 8'h00, 8'h00, 8'h00};
    model(256);
    run_stream(0, 1'b1);

    // ADDR_W=2 full capacity, then trailing bytes must not be taken
    sq.delete();
    sq.push_back(8'h04);
    sq.push_back(8'h00);
    for (int i = 0; i < 16; i++) sq.push_back(8'($urandom));
    model(4);
    run_stream(1, 1'b0);
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      chk("trail_rdy", if2.rx_ready, 1'b0);
      step();
    end
    rx_valid = 1'b0;
    chk("trail_writes", q2.size(), 4);
    chk("trail_done", if2.done, 1'b1);

    // ADDR_W=8 full capacity
    sq.delete();
    sq.push_back(8'h00);
    sq.push_back(8'h01);
    for (int i = 0; i < 1024; i++) sq.push_back(8'($urandom));
    model(256);
    run_stream(0, 1'b0);

    // randomized streams against the model
    for (int it = 0; it < 16; it++) begin
      int s;
      int cap;
      int n;
      int m;
      s   = int'($urandom_range(1, 0));
      cap = (s == 1) ? 4 : 256;
      m   = int'($urandom_range(9, 0));
      if (m == 0) n = 0;
      else if (m == 1) n = cap + 1 + int'($urandom_range(3, 0));
      else n = int'($urandom_range((cap < 6) ? cap : 6, 1));
      sq.delete();
      sq.push_back(8'(n));
      sq.push_back(8'(n >> 8));
      if (n <= cap)
        for (int i = 0; i < 4 * n; i++) sq.push_back(8'($urandom));
      model(cap);
      run_stream(s, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
